vc_control: RTL and testbench

Control FSM for the victim cache datapath (vc_datapath). It sequences every victim-cache transaction: L1 evictions into the buffer, L1 miss lookups, and write-back of displaced entries to the next memory level. It also bridges the upper-level and lower-level request/response handshakes, and keeps saturating event counters for performance analysis.

---
 rtl/vc_control.sv | 143 ++++++++++++++
 tb/tb_vc_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_control.sv
// vc_control: transaction sequencer for the victim cache datapath.
// Serves L1 evictions (fill, overwrite on hit, or write-back then fill),
// L1 miss lookups (hit from an entry or forward to the next level), and
// keeps saturating performance counters.
module vc_control #(
  parameter  int entries = 8,
  localparam int IW      = $clog2(entries)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  input  logic          pmem_resp,
  input  logic          full,
  input  logic          hit,
  input  logic [IW-1:0] hit_idx,
  input  logic [IW-1:0] circular_idx,
  output logic [IW-1:0] idx,
  output logic          load,
  output logic          circular_inc,
  output logic          read_sel,
  output logic          out_sel,
  output logic [31:0]   rd_hits,
  output logic [31:0]   rd_misses,
  output logic [31:0]   writebacks
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_HIT    = 3'd1,
    RD_MISS   = 3'd2,
    WR_HIT    = 3'd3,
    WRITEBACK = 3'd4,
    FILL      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rd_hits_q, rd_hits_d;
  logic [31:0] rd_misses_q, rd_misses_d;
  logic [31:0] writebacks_q, writebacks_d;
  logic        hit_evt, miss_evt, wb_evt;

  // State and counter registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_hits_q    <= '0;
      rd_misses_q  <= '0;
      writebacks_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_hits_q    <= rd_hits_d;
      rd_misses_q  <= rd_misses_d;
      writebacks_q <= writebacks_d;
    end
  end

  // Next state and Moore outputs; mem_resp in RD_MISS follows pmem_resp.
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    idx          = '0;
    load         = 1'b0;
    circular_inc = 1'b0;
    read_sel     = 1'b0;
    out_sel      = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    wb_evt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          if (hit)        state_d = WR_HIT;
          else if (!full) state_d = FILL;
          else            state_d = WRITEBACK;
        end else if (mem_read) begin
          state_d = hit ? RD_HIT : RD_MISS;
        end
      end
      RD_HIT: begin
        idx      = hit_idx;
        read_sel = 1'b1;
        mem_resp = 1'b1;
        hit_evt  = 1'b1;
        state_d  = IDLE;
      end
      RD_MISS: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          mem_resp = 1'b1;
          miss_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      WR_HIT: begin
        idx      = hit_idx;
        load     = 1'b1;
        mem_resp = 1'b1;
        state_d  = IDLE;
      end
      WRITEBACK: begin
        idx        = circular_idx;
        out_sel    = 1'b1;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wb_evt  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        idx          = circular_idx;
        load         = 1'b1;
        circular_inc = 1'b1;
        mem_resp     = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating counter updates; a full counter holds rather than wrapping.
  always_comb begin
    rd_hits_d    = rd_hits_q;
    rd_misses_d  = rd_misses_q;
    writebacks_d = writebacks_q;
    if (hit_evt && (rd_hits_q != 32'hFFFF_FFFF))
      rd_hits_d = rd_hits_q + 32'd1;
    if (miss_evt && (rd_misses_q != 32'hFFFF_FFFF))
      rd_misses_d = rd_misses_q + 32'd1;
    if (wb_evt && (writebacks_q != 32'hFFFF_FFFF))
      writebacks_d = writebacks_q + 32'd1;
  end

  assign rd_hits    = rd_hits_q;
  assign rd_misses  = rd_misses_q;
  assign writebacks = writebacks_q;

endmodule

// File: tb/tb_vc_control.sv
// tb_vc_control: directed scenarios for the victim cache controller.
// The bench plays both the L1 requester and the datapath (hit/full/indices)
// and checks outputs on the falling edge, away from the active edge.
module tb_vc_control;

  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read, mem_write, mem_resp;
  logic          pmem_read, pmem_write, pmem_resp;
  logic          full, hit;
  logic [IW-1:0] hit_idx, circular_idx, idx;
  logic          load, circular_inc, read_sel, out_sel;
  logic [31:0]   rd_hits, rd_misses, writebacks;

  int errors = 0;
  int checks = 0;

  vc_control #(.entries(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .full(full), .hit(hit), .hit_idx(hit_idx), .circular_idx(circular_idx),
    .idx(idx), .load(load), .circular_inc(circular_inc),
    .read_sel(read_sel), .out_sel(out_sel),
    .rd_hits(rd_hits), .rd_misses(rd_misses), .writebacks(writebacks)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Packed view of all strobes/selects: {mem_resp,pmem_read,pmem_write,load,circular_inc,read_sel,out_sel,idx}.
  logic [9:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, load, circular_inc,
                 read_sel, out_sel, idx};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    hit       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); full = 1'b0;
    hit_idx = '0; circular_idx = '0;
    #1;
    checks++;
    if (outs !== 10'b0 || rd_hits !== 0 || rd_misses !== 0 || writebacks !== 0) begin
      errors++;
      $display("FAIL reset_state: outs=%b cnt=%0d/%0d/%0d required outs=0 cnt=0", outs, rd_hits, rd_misses, writebacks);
    end
    @(negedge clk); rst_n = 1'b1; tick();
    // Start a read miss, then reset while it is outstanding.
    mem_read = 1'b1; hit = 1'b0;
    tick();
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL reset_pre_miss: pmem_read=%b required 1", pmem_read);
    end
    #2 rst_n = 1'b0; mem_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || mem_resp !== 1'b0 || rd_misses !== 0) begin
      errors++;
      $display("FAIL reset_mid_miss: pmem_read=%b mem_resp=%b rd_misses=%0d required 0/0/0", pmem_read, mem_resp, rd_misses);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    // Late pmem_resp in IDLE is ignored.
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++; $display("FAIL reset_late_resp: outs=%b required 0", outs);
    end
    tick(); pmem_resp = 1'b0; tick();
    checks++;
    if (outs !== 10'b0 || rd_misses !== 0) begin
      errors++; $display("FAIL reset_idle_after: outs=%b rd_misses=%0d required 0/0", outs, rd_misses);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      mem_write = 1'b1; hit = 1'b0; full = 1'b0;
      circular_idx = IW'(i);
      tick();
      checks++;
      if (outs !== {7'b1001100, IW'(i)}) begin
        errors++; $display("FAIL fill_%0d: outs=%b required %b", i, outs, {7'b1001100, IW'(i)});
      end
      mem_write = 1'b0;
      tick();
    end
    full = 1'b1; circular_idx = '0;
  endtask

  task automatic test_writeback();
    mem_write = 1'b1; hit = 1'b0; full = 1'b1; circular_idx = 3'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (outs !== 10'b0010001_000) begin
        errors++; $display("FAIL wb_wait_%0d: outs=%b required 0010001000", c, outs);
      end
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b0 || pmem_write !== 1'b1) begin
      errors++; $display("FAIL wb_resp_cycle: mem_resp=%b pmem_write=%b required 0/1", mem_resp, pmem_write);
    end
    tick();
    pmem_resp = 1'b0;
    checks++;
    if (outs !== 10'b1001100_000 || writebacks !== 32'd1) begin
      errors++; $display("FAIL wb_fill: outs=%b writebacks=%0d required 1001100000/1", outs, writebacks);
    end
    mem_write = 1'b0; circular_idx = 3'd1;
    tick();
  endtask

  task automatic test_read_hit();
    mem_read = 1'b1; hit = 1'b1; hit_idx = 3'd1;
    tick();
    checks++;
    if (outs !== 10'b1000010_001) begin
      errors++; $display("FAIL rd_hit: outs=%b required 1000010001", outs);
    end
    mem_read = 1'b0; hit = 1'b0;
    tick();
    checks++;
    if (rd_hits !== 32'd1 || mem_resp !== 1'b0) begin
      errors++; $display("FAIL rd_hit_count: rd_hits=%0d mem_resp=%b required 1/0", rd_hits, mem_resp);
    end
  endtask

  task automatic test_read_miss();
    mem_read = 1'b1; hit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (outs !== 10'b0100000_000) begin
        errors++; $display("FAIL rd_miss_wait_%0d: outs=%b required 0100000000", c, outs);
      end
    end
    tick();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (outs !== 10'b1100000_000) begin
      errors++; $display("FAIL rd_miss_resp: outs=%b required 1100000000", outs);
    end
    tick();
    pmem_resp = 1'b0; mem_read = 1'b0;
    checks++;
    if (rd_misses !== 32'd1 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL rd_miss_count: rd_misses=%0d pmem_read=%b required 1/0", rd_misses, pmem_read);
    end
  endtask

  task automatic test_wr_hit();
    mem_write = 1'b1; hit = 1'b1; hit_idx = 3'd2; full = 1'b1;
    tick();
    checks++;
    if (outs !== 10'b1001000_010) begin
      errors++; $display("FAIL wr_hit: outs=%b required 1001000010", outs);
    end
    mem_write = 1'b0; hit = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    force dut.rd_misses_q = 32'hFFFF_FFFF;
    tick();
    release dut.rd_misses_q;
    tick();
    full = 1'b0; circular_idx = 3'd1;
    mem_read = 1'b1; mem_write = 1'b1; hit = 1'b0;
    tick();
    checks++;
    if (outs !== 10'b1001100_001) begin
      errors++; $display("FAIL b2b_write_first: outs=%b required 1001100001", outs);
    end
    mem_write = 1'b0;
    tick();
    checks++;
    if (outs !== 10'b0) begin
      errors++; $display("FAIL b2b_idle_gap: outs=%b required 0", outs);
    end
    tick();
    checks++;
    if (outs !== 10'b0100000_000) begin
      errors++; $display("FAIL b2b_read_miss: outs=%b required 0100000000", outs);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL b2b_read_resp: mem_resp=%b required 1", mem_resp);
    end
    tick();
    pmem_resp = 1'b0; mem_read = 1'b0;
    checks++;
    if (rd_misses !== 32'hFFFF_FFFF || outs !== 10'b0) begin
      errors++; $display("FAIL b2b_saturate: rd_misses=%h outs=%b required ffffffff/0", rd_misses, outs);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_read_hit();
    test_read_miss();
    test_wr_hit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
